// File: rtl/cnt_rate_pkg.sv
// Shared definitions for the count-rate meter: default widths and FSM states.
package cnt_rate_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned WIN_W_DEF = 16;
  localparam int unsigned DROP_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_delta_step.sv
// Per-cycle increment of a wrap-around count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   cnt_in     : free-running count, synchronous to clk
//   mask       : force the delta to zero (not counting, or priming)
//   delta_c    : (cnt_in - previous cnt_in) mod 2^W, zero-extended to ACC_W
module cnt_delta_step
  import cnt_rate_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     cnt_in,
  input  logic             mask,
  output logic [ACC_W-1:0] delta_c
);

  logic [W-1:0] prev;
  logic [W-1:0] diff_c;

  // Previous sample, taken every cycle regardless of mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= cnt_in;
    end
  end

  // Modulo subtraction handles the wrap; jumps of 2^W or more alias
  assign diff_c  = cnt_in - prev;
  assign delta_c = mask ? '0 : ACC_W'(diff_c);

endmodule

// File: rtl/cnt_rate_meter.sv
// Windowed rate meter for a wrap-around count: accumulates count increments
// over programmable windows, hands each window result to a consumer through a
// single holding register, and keeps a running total.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   en              : measurement enable
//   cnt_in          : free-running count (W bits)
//   win_len         : window length in cycles, 0 behaves as 1
//   m_valid/m_ready : result handshake
//   m_count, m_ovf  : last closed window's increment count and saturation flag
//   total           : running sum of counted increments (wraps)
//   drop_cnt        : results lost to backpressure (saturating)
module cnt_rate_meter
  import cnt_rate_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [W-1:0]      cnt_in,
  input  logic [WIN_W-1:0]  win_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_count,
  output logic              m_ovf,
  output logic [ACC_W-1:0]  total,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [WIN_W-1:0]   timer;
  logic               win_ovf;

  logic               run_c;
  logic               close_c;
  logic [ACC_W-1:0]   delta_c;
  logic [WIN_W-1:0]   win_reload_c;
  logic [ACC_W:0]     sum_c;
  logic               sat_c;
  logic [ACC_W-1:0]   acc_sat_c;

  // Counting happens only in RUN with enable still high
  assign run_c   = (state == RUN) && en;
  assign close_c = run_c && (timer == '0);

  cnt_delta_step #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_delta (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_in  (cnt_in),
    .mask    (!run_c),
    .delta_c (delta_c)
  );

  // Timer counts win_len_eff-1 down to 0, so a window is win_len_eff RUN cycles
  assign win_reload_c = (win_len == '0) ? '0 : win_len - WIN_W'(1);

  // Saturating window accumulation
  assign sum_c     = {1'b0, acc} + {1'b0, delta_c};
  assign sat_c     = sum_c[ACC_W];
  assign acc_sat_c = sat_c ? '1 : sum_c[ACC_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; dropping en from PRIME or RUN abandons the window
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = en ? PRIME : IDLE;
      PRIME:   state_nxt = en ? RUN : IDLE;
      RUN:     state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window accumulator, window timer and running total
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      timer   <= '0;
      win_ovf <= 1'b0;
      total   <= '0;
    end else if (state == PRIME) begin
      acc     <= '0;
      win_ovf <= 1'b0;
      timer   <= win_reload_c;
    end else if (run_c) begin
      total <= total + delta_c;
      if (timer == '0) begin
        // Next window starts immediately with the current win_len
        acc     <= '0;
        win_ovf <= 1'b0;
        timer   <= win_reload_c;
      end else begin
        acc     <= acc_sat_c;
        win_ovf <= win_ovf | sat_c;
        timer   <= timer - WIN_W'(1);
      end
    end
  end

  // Single-entry result holder; a close can only land if the slot is free
  // or being emptied in the same cycle, otherwise the new result is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_count  <= '0;
      m_ovf    <= 1'b0;
      drop_cnt <= '0;
    end else if (close_c) begin
      if (!m_valid || m_ready) begin
        m_valid <= 1'b1;
        m_count <= acc_sat_c;
        m_ovf   <= win_ovf | sat_c;
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_rate_meter.sv
// Self-checking bench for cnt_rate_meter: a wide (ACC_W=32) and a narrow
// (ACC_W=8) instance share stimulus and are compared every cycle against a
// window-sum model, plus directed cases with hand-computed values.
module tb_cnt_rate_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        m_ready;
  logic [7:0]  cnt_in;
  logic [15:0] win_len;

  logic        a_m_valid, a_m_ovf;
  logic [31:0] a_m_count, a_total;
  logic [7:0]  a_drop;
  logic        b_m_valid, b_m_ovf;
  logic [7:0]  b_m_count, b_total;
  logic [7:0]  b_drop;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cnt_rate_meter #(.W(8), .ACC_W(32), .WIN_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in), .win_len(win_len),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_count(a_m_count),
    .m_ovf(a_m_ovf), .total(a_total), .drop_cnt(a_drop)
  );

  cnt_rate_meter #(.W(8), .ACC_W(8), .WIN_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in), .win_len(win_len),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_count(b_m_count),
    .m_ovf(b_m_ovf), .total(b_total), .drop_cnt(b_drop)
  );

  // Model: mode 0 off, 1 priming, 2 counting. Window sums are kept unbounded;
  // each instance's result is that sum clamped to its own accumulator range.
  int     md_mode;
  int     md_left;
  int     md_last;
  longint md_wsum;
  longint md_total;
  bit     md_pvalid;
  longint md_psum;
  int     md_drops;

  localparam longint MAX_A = 64'd4294967295;
  localparam longint MAX_B = 64'd255;

  function automatic int eff_len(input logic [15:0] wl);
    return (wl == 16'd0) ? 1 : int'(wl);
  endfunction

  function automatic longint clamp(input longint s, input longint mx);
    return (s > mx) ? mx : s;
  endfunction

  task automatic mdl_reset();
    md_mode = 0; md_left = 0; md_last = 0; md_wsum = 0; md_total = 0;
    md_pvalid = 1'b0; md_psum = 0; md_drops = 0;
  endtask

  task automatic mdl_clock();
    longint d;
    longint csum;
    bit     close;
    if (!rst_n) begin
      mdl_reset();
      return;
    end
    d     = longint'((int'(cnt_in) - md_last) & 255);
    close = 1'b0;
    csum  = 0;
    if (md_mode == 2 && en) begin
      md_wsum  = md_wsum + d;
      md_total = (md_total + d) & 64'hFFFF_FFFF;
      md_left  = md_left - 1;
      if (md_left == 0) begin
        close   = 1'b1;
        csum    = md_wsum;
        md_wsum = 0;
        md_left = eff_len(win_len);
      end
    end else if (md_mode == 1) begin
      md_wsum = 0;
      md_left = eff_len(win_len);
    end
    if (close) begin
      if (!md_pvalid || m_ready) begin
        md_pvalid = 1'b1;
        md_psum   = csum;
      end else if (md_drops < 255) begin
        md_drops++;
      end
    end else if (md_pvalid && m_ready) begin
      md_pvalid = 1'b0;
    end
    if (!en)               md_mode = 0;
    else if (md_mode == 0) md_mode = 1;
    else                   md_mode = 2;
    md_last = int'(cnt_in);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_valid", 64'(a_m_valid), 64'(md_pvalid));
    check("b_valid", 64'(b_m_valid), 64'(md_pvalid));
    check("a_total", 64'(a_total), 64'(md_total));
    check("b_total", 64'(b_total), 64'(md_total & 255));
    check("a_drop", 64'(a_drop), 64'(md_drops));
    check("b_drop", 64'(b_drop), 64'(md_drops));
    if (md_pvalid) begin
      check("a_count", 64'(a_m_count), 64'(clamp(md_psum, MAX_A)));
      check("a_ovf", 64'(a_m_ovf), 64'(md_psum > MAX_A));
      check("b_count", 64'(b_m_count), 64'(clamp(md_psum, MAX_B)));
      check("b_ovf", 64'(b_m_ovf), 64'(md_psum > MAX_B));
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_clock();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mdl_reset();
    #1;
    compare_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int valids;
    int first_c;
    int third_c;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; cnt_in = 8'h00; win_len = 16'd50;
    mdl_reset();
    @(negedge clk);

    // Reset with a nonzero count, then a PRIME cycle that sees a count jump
    cnt_in = 8'h37;
    do_reset();
    check("rst_valid", 64'(a_m_valid), 64'd0);
    check("rst_count", 64'(a_m_count), 64'd0);
    check("rst_ovf", 64'(a_m_ovf), 64'd0);
    check("rst_total", 64'(a_total), 64'd0);
    check("rst_drop", 64'(a_drop), 64'd0);
    step();
    en = 1'b1;
    step();
    cnt_in = 8'h40;
    step();
    step();
    step();
    check("prime_total", 64'(a_total), 64'd0);

    // win_len=10, +1 per cycle across the 8-bit wrap
    en = 1'b0; win_len = 16'd10; m_ready = 1'b1; cnt_in = 8'hF8;
    do_reset();
    en = 1'b1;
    valids = 0; first_c = 0; third_c = 0;
    for (int c = 0; c < 60 && valids < 3; c++) begin
      cnt_in = cnt_in + 8'd1;
      step();
      if (a_m_valid) begin
        valids++;
        check("w10_count", 64'(a_m_count), 64'd10);
        if (valids == 1) first_c = c;
        if (valids == 3) begin
          third_c = c;
          check("w10_total", 64'(a_total), 64'd30);
        end
      end
    end
    check("w10_windows", 64'(valids), 64'd3);
    check("w10_spacing", 64'(third_c - first_c), 64'd20);

    // Single-cycle wrap jump 0xFE -> 0x03, then enable drop holds total
    en = 1'b0; win_len = 16'd100; cnt_in = 8'hFE;
    do_reset();
    en = 1'b1;
    step(); step(); step();
    cnt_in = 8'h03;
    step();
    check("jump_total", 64'(a_total), 64'd5);
    en = 1'b0; cnt_in = 8'h10;
    step();
    check("en_off_total", 64'(a_total), 64'd5);

    // Backpressure across two closes, then accept on a close cycle
    win_len = 16'd3; m_ready = 1'b0; cnt_in = 8'h00;
    do_reset();
    en = 1'b1;
    step(); step();
    for (int k = 1; k <= 10; k++) begin
      cnt_in  = cnt_in + ((k <= 3) ? 8'd2 : 8'd3);
      m_ready = (k >= 9);
      step();
      if (k == 3) begin
        check("bp_first_valid", 64'(a_m_valid), 64'd1);
        check("bp_first_count", 64'(a_m_count), 64'd6);
      end
      if (k == 6) begin
        check("bp_held_count", 64'(a_m_count), 64'd6);
        check("bp_drop1", 64'(a_drop), 64'd1);
      end
      if (k == 9) begin
        check("bp_swap_count", 64'(a_m_count), 64'd9);
        check("bp_swap_drop", 64'(a_drop), 64'd1);
        check("bp_swap_valid", 64'(a_m_valid), 64'd1);
      end
      if (k == 10) check("bp_empty", 64'(a_m_valid), 64'd0);
    end

    // Narrow accumulator saturation, then a clean window
    en = 1'b0; win_len = 16'd4; m_ready = 1'b1; cnt_in = 8'h00;
    do_reset();
    en = 1'b1;
    step(); step();
    for (int k = 1; k <= 8; k++) begin
      cnt_in = cnt_in + ((k <= 4) ? 8'hFF : 8'h01);
      step();
      if (k == 4) begin
        check("sat_b_count", 64'(b_m_count), 64'hFF);
        check("sat_b_ovf", 64'(b_m_ovf), 64'd1);
        check("sat_a_count", 64'(a_m_count), 64'd1020);
        check("sat_a_ovf", 64'(a_m_ovf), 64'd0);
      end
      if (k == 8) begin
        check("clean_b_count", 64'(b_m_count), 64'd4);
        check("clean_b_ovf", 64'(b_m_ovf), 64'd0);
      end
    end

    // Enable drop mid-window with a pending result, then reset clears it
    en = 1'b0; win_len = 16'd5; m_ready = 1'b0; cnt_in = 8'h10;
    do_reset();
    en = 1'b1;
    step(); step();
    for (int k = 1; k <= 6; k++) begin
      cnt_in = cnt_in + 8'd1;
      step();
    end
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cnt_in = cnt_in + 8'd1;
      step();
    end
    check("hold_valid", 64'(a_m_valid), 64'd1);
    check("hold_count", 64'(a_m_count), 64'd5);
    check("hold_drop", 64'(a_drop), 64'd0);
    do_reset();
    check("rst2_valid", 64'(a_m_valid), 64'd0);
    check("rst2_drop", 64'(a_drop), 64'd0);

    // Drop counter saturation: one-cycle windows with no consumer
    win_len = 16'd0; m_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cnt_in = cnt_in + 8'd1;
      step();
    end
    check("drop_sat", 64'(a_drop), 64'hFF);

    // Randomized traffic against the model
    m_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      en      = ($urandom_range(0, 15) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      win_len = 16'($urandom_range(0, 6));
      case ($urandom_range(0, 9))
        0, 1:    cnt_in = cnt_in + 8'($urandom_range(0, 255));
        2:       cnt_in = cnt_in + 8'hFF;
        default: cnt_in = cnt_in + 8'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
